// File: rtl/uniboard_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uniboard_cmd_pkg
// Shared definitions for the UART command controller: the controller state
// encoding, response status codes, default framing bytes, the bit position of
// the write flag in the command byte, and a helper that picks one response
// byte out of the 4-byte response frame.
// -----------------------------------------------------------------------------
package uniboard_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_CMD   = 4'd1,
        ST_GET_DATA  = 4'd2,
        ST_GET_CHK   = 4'd3,
        ST_EXEC      = 4'd4,
        ST_READ_WAIT = 4'd5,
        ST_TX_LOAD   = 4'd6,
        ST_TX_ACK    = 4'd7,
        ST_TX_DONE   = 4'd8
    } cmd_state_t;

    localparam logic [7:0] STATUS_OK         = 8'h00;
    localparam logic [7:0] STATUS_BADCHK     = 8'h01;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEFAULT_RESP_BYTE = 8'h5A;
    localparam int         CMD_WRITE_BIT     = 7;

    // Response frame: RESP, STATUS, DATA, STATUS^DATA
    function automatic logic [7:0] resp_byte_sel(
        input logic [1:0] idx,
        input logic [7:0] resp,
        input logic [7:0] status,
        input logic [7:0] data
    );
        logic [7:0] sel;
        case (idx)
            2'd0:    sel = resp;
            2'd1:    sel = status;
            2'd2:    sel = data;
            default: sel = status ^ data;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// -----------------------------------------------------------------------------
// uart_tx_handshake
// Hands one byte at a time to the UART transmitter using a level request:
// tx_send rises with the byte on tx_data, drops once the transmitter's busy
// flag is seen high, and the byte is complete once busy is seen low again.
// tx_busy comes from the baud-clock domain and is synchronised with two flops.
//
// Ports:
//   clk_i     in   module clock
//   reset     in   synchronous active-high reset
//   i_start   in   1-cycle request to send i_byte (accepted only when idle)
//   i_byte    in   byte to send
//   tx_busy   in   transmitter busy (asynchronous)
//   tx_data   out  byte to transmitter, stable while tx_send is high
//   tx_send   out  transmitter start request (level)
//   o_acked   out  1-cycle pulse: transmitter accepted the byte
//   o_done    out  1-cycle pulse: transmitter finished the byte
// -----------------------------------------------------------------------------
module uart_tx_handshake (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic       o_acked,
    output logic       o_done
);

    localparam logic [1:0] HS_IDLE = 2'd0;
    localparam logic [1:0] HS_ACK  = 2'd1;
    localparam logic [1:0] HS_DONE = 2'd2;

    logic [1:0] r_phase;
    logic       r_busy_meta;
    logic       r_busy_sync;
    logic [7:0] r_tx_data;
    logic       r_tx_send;
    logic       r_acked;
    logic       r_done;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_phase     <= HS_IDLE;
            r_busy_meta <= 1'b0;
            r_busy_sync <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_send   <= 1'b0;
            r_acked     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy_meta <= tx_busy;
            r_busy_sync <= r_busy_meta;
            r_acked     <= 1'b0;
            r_done      <= 1'b0;
            case (r_phase)
                HS_IDLE: begin
                    if (i_start) begin
                        r_tx_data <= i_byte;
                        r_tx_send <= 1'b1;
                        r_phase   <= HS_ACK;
                    end
                end
                HS_ACK: begin
                    if (r_busy_sync) begin
                        r_tx_send <= 1'b0;
                        r_acked   <= 1'b1;
                        r_phase   <= HS_DONE;
                    end
                end
                HS_DONE: begin
                    // Next start can only follow this, so a new request never
                    // rises while the synchronised busy is still high.
                    if (!r_busy_sync) begin
                        r_done  <= 1'b1;
                        r_phase <= HS_IDLE;
                    end
                end
                default: r_phase <= HS_IDLE;
            endcase
        end
    end

    assign tx_data = r_tx_data;
    assign tx_send = r_tx_send;
    assign o_acked = r_acked;
    assign o_done  = r_done;

endmodule

// File: rtl/uart_cmd_controller.sv
// -----------------------------------------------------------------------------
// uart_cmd_controller
// Turns received UART bytes into framed register accesses and answers each
// accepted frame with a 4-byte response.
//   Command:  SYNC, CMD, [DATA if CMD[7]], CHK   (CHK = CMD^DATA or CMD)
//   Response: RESP, STATUS, DATA, STATUS^DATA
// A stalled frame (no byte for TIMEOUT_CYCLES) is abandoned with a frame_err
// pulse and no response. Bytes arriving while a frame executes or its
// response is being sent are dropped.
//
// Ports:
//   clk_i      in   module clock
//   reset      in   synchronous active-high reset
//   rx_data    in   received byte, sampled on the rising edge of rx_drdy
//   rx_drdy    in   receiver data-ready
//   tx_data    out  byte to transmitter
//   tx_send    out  transmitter start request
//   tx_busy    in   transmitter busy (asynchronous)
//   reg_addr   out  register address
//   reg_wdata  out  register write data
//   reg_we     out  1-cycle write strobe
//   reg_re     out  1-cycle read strobe
//   reg_rdata  in   read data, valid the cycle after reg_re
//   frame_err  out  1-cycle pulse on timeout or bad checksum
//   active     out  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module uart_cmd_controller
    import uniboard_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [7:0] RESP_BYTE      = DEFAULT_RESP_BYTE
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_drdy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err,
    output logic       active
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    cmd_state_t    r_state;
    logic          r_drdy_q;
    logic [7:0]    r_cmd;
    logic [7:0]    r_data;
    logic          r_chk_ok;
    logic [7:0]    r_status;
    logic [7:0]    r_resp_data;
    logic [1:0]    r_byte_idx;
    logic [TW-1:0] r_timer;
    logic          r_frame_err;

    logic          w_byte_evt;
    logic          w_is_write;
    logic          w_timeout;
    logic          w_in_rx;
    logic [7:0]    w_exp_chk;
    logic          w_hs_start;
    logic [7:0]    w_hs_byte;
    logic          w_hs_acked;
    logic          w_hs_done;

    assign w_byte_evt = rx_drdy & ~r_drdy_q;
    assign w_is_write = r_cmd[CMD_WRITE_BIT];
    assign w_timeout  = (r_timer == TIMER_MAX);
    assign w_in_rx    = (r_state == ST_GET_CMD) || (r_state == ST_GET_DATA) ||
                        (r_state == ST_GET_CHK);
    assign w_exp_chk  = w_is_write ? (r_cmd ^ r_data) : r_cmd;

    // Timer clears on every byte event; GET_CMD is only ever entered on a
    // byte event, so that also covers the clear on entry. Saturates at max.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_byte_evt) begin
            r_timer <= '0;
        end else if (!w_timeout) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drdy_q    <= 1'b0;
            r_cmd       <= 8'h00;
            r_data      <= 8'h00;
            r_chk_ok    <= 1'b0;
            r_status    <= 8'h00;
            r_resp_data <= 8'h00;
            r_byte_idx  <= 2'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_drdy_q    <= rx_drdy;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_evt && (rx_data == SYNC_BYTE)) begin
                        r_data  <= 8'h00;
                        r_state <= ST_GET_CMD;
                    end
                end
                ST_GET_CMD: begin
                    if (w_byte_evt) begin
                        r_cmd   <= rx_data;
                        r_state <= rx_data[CMD_WRITE_BIT] ? ST_GET_DATA : ST_GET_CHK;
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_GET_DATA: begin
                    if (w_byte_evt) begin
                        r_data  <= rx_data;
                        r_state <= ST_GET_CHK;
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_GET_CHK: begin
                    if (w_byte_evt) begin
                        r_chk_ok <= (rx_data == w_exp_chk);
                        r_state  <= ST_EXEC;
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_byte_idx <= 2'd0;
                    if (!r_chk_ok) begin
                        r_frame_err <= 1'b1;
                        r_status    <= STATUS_BADCHK;
                        r_resp_data <= 8'h00;
                        r_state     <= ST_TX_LOAD;
                    end else if (w_is_write) begin
                        r_status    <= STATUS_OK;
                        r_resp_data <= r_data;
                        r_state     <= ST_TX_LOAD;
                    end else begin
                        r_status <= STATUS_OK;
                        r_state  <= ST_READ_WAIT;
                    end
                end
                ST_READ_WAIT: begin
                    // reg_re was high in EXEC, so read data is valid now
                    r_resp_data <= reg_rdata;
                    r_state     <= ST_TX_LOAD;
                end
                ST_TX_LOAD: begin
                    r_state <= ST_TX_ACK;
                end
                ST_TX_ACK: begin
                    if (w_hs_acked) begin
                        r_state <= ST_TX_DONE;
                    end
                end
                ST_TX_DONE: begin
                    if (w_hs_done) begin
                        if (r_byte_idx == 2'd3) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= ST_TX_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_hs_start = (r_state == ST_TX_LOAD);
    assign w_hs_byte  = resp_byte_sel(r_byte_idx, RESP_BYTE, r_status, r_resp_data);

    uart_tx_handshake u_tx_hs (
        .clk_i   (clk_i),
        .reset   (reset),
        .i_start (w_hs_start),
        .i_byte  (w_hs_byte),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .o_acked (w_hs_acked),
        .o_done  (w_hs_done)
    );

    // Strobes decode the registered state so they last exactly the EXEC cycle
    assign reg_we    = (r_state == ST_EXEC) && r_chk_ok && w_is_write;
    assign reg_re    = (r_state == ST_EXEC) && r_chk_ok && !w_is_write;
    assign reg_addr  = r_cmd[6:0];
    assign reg_wdata = r_data;
    assign frame_err = r_frame_err;
    assign active    = (r_state != ST_IDLE);

endmodule
